// File: rtl/endgame_sequencer_if.sv
// endgame_sequencer_if
//   Bundles the game-logic events and the banner/playfield controls of the
//   end-of-game sequencer.
//   master : game logic side (drives events, receives controls)
//   slave  : sequencer side  (receives events, drives controls)
//   Events  : player_hit, wave_cleared (1-cycle pulses), invaders_landed
//             (level), start_btn (synchronised level)
//   Controls: loser, winner, game_freeze, game_restart, lives[1:0],
//             state[2:0] (debug)
interface endgame_sequencer_if;
  logic       player_hit;
  logic       wave_cleared;
  logic       invaders_landed;
  logic       start_btn;
  logic       loser;
  logic       winner;
  logic       game_freeze;
  logic       game_restart;
  logic [1:0] lives;
  logic [2:0] state;

  modport master (
    output player_hit, wave_cleared, invaders_landed, start_btn,
    input  loser, winner, game_freeze, game_restart, lives, state
  );

  modport slave (
    input  player_hit, wave_cleared, invaders_landed, start_btn,
    output loser, winner, game_freeze, game_restart, lives, state
  );
endinterface

// File: rtl/endgame_sequencer.sv
// endgame_sequencer
//   Sequences the end-of-game flow: play, freeze the playfield, scroll in the
//   winner/loser banner, hold it, then return to attract mode. Owns the lives
//   count and issues the one-cycle restart pulse when a game starts.
//   clk : pixel clock
//   rst : asynchronous, active-high reset
//   bus : endgame_sequencer_if.slave (events in, banner/freeze/restart,
//         lives and debug state out)
module endgame_sequencer #(
  parameter int TICK_DIV     = 2000000,
  parameter int FREEZE_TICKS = 30,
  parameter int SCROLL_TICKS = 160,
  parameter int HOLD_TICKS   = 100,
  parameter int LIVES        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  endgame_sequencer_if.slave   bus
);

  localparam int MAX_FS = (FREEZE_TICKS > SCROLL_TICKS) ? FREEZE_TICKS : SCROLL_TICKS;
  localparam int MAX_T  = (MAX_FS > HOLD_TICKS) ? MAX_FS : HOLD_TICKS;
  localparam int PW     = $clog2(MAX_T + 1);
  localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    FREEZE = 3'd2,
    SCROLL = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t        st;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase;
  logic          tick;
  logic          start_q;
  logic          start_edge;
  logic          res_lose;
  logic [1:0]    lives_r;
  logic          loser_r;
  logic          winner_r;
  logic          freeze_r;
  logic          restart_r;
  logic          freeze_done;
  logic          scroll_done;
  logic          hold_done;

  assign tick        = (tick_cnt == TW'(TICK_DIV - 1));
  assign start_edge  = bus.start_btn & ~start_q;
  // Final tick of each timed state; the transition lands on the next cycle.
  assign freeze_done = tick && (phase == PW'(FREEZE_TICKS - 1));
  assign scroll_done = tick && (phase == PW'(SCROLL_TICKS - 1));
  assign hold_done   = tick && (phase == PW'(HOLD_TICKS - 1));

  // Counters advance first; any transition below re-assigns them to zero and,
  // being the later non-blocking assignment, wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      tick_cnt  <= '0;
      phase     <= '0;
      start_q   <= 1'b1;
      res_lose  <= 1'b0;
      lives_r   <= 2'(LIVES);
      loser_r   <= 1'b0;
      winner_r  <= 1'b0;
      freeze_r  <= 1'b1;
      restart_r <= 1'b0;
    end else begin
      start_q   <= bus.start_btn;
      restart_r <= 1'b0;
      if (tick) begin
        tick_cnt <= '0;
        phase    <= phase + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      case (st)
        IDLE: begin
          if (start_edge) begin
            st        <= PLAY;
            restart_r <= 1'b1;
            lives_r   <= 2'(LIVES);
            freeze_r  <= 1'b0;
            tick_cnt  <= '0;
            phase     <= '0;
          end
        end

        PLAY: begin
          if (bus.invaders_landed) begin
            lives_r  <= '0;
            res_lose <= 1'b1;
            st       <= FREEZE;
            freeze_r <= 1'b1;
            tick_cnt <= '0;
            phase    <= '0;
          end else if (bus.player_hit) begin
            if (lives_r != '0) lives_r <= lives_r - 2'd1;
            if (lives_r <= 2'd1) begin
              res_lose <= 1'b1;
              st       <= FREEZE;
              freeze_r <= 1'b1;
              tick_cnt <= '0;
              phase    <= '0;
            end
          end else if (bus.wave_cleared) begin
            res_lose <= 1'b0;
            st       <= FREEZE;
            freeze_r <= 1'b1;
            tick_cnt <= '0;
            phase    <= '0;
          end
        end

        FREEZE: begin
          if (freeze_done) begin
            st       <= SCROLL;
            loser_r  <= res_lose;
            winner_r <= ~res_lose;
            tick_cnt <= '0;
            phase    <= '0;
          end
        end

        SCROLL: begin
          if (scroll_done) begin
            st       <= HOLD;
            tick_cnt <= '0;
            phase    <= '0;
          end
        end

        HOLD: begin
          if (start_edge) begin
            st        <= PLAY;
            restart_r <= 1'b1;
            lives_r   <= 2'(LIVES);
            freeze_r  <= 1'b0;
            loser_r   <= 1'b0;
            winner_r  <= 1'b0;
            tick_cnt  <= '0;
            phase     <= '0;
          end else if (hold_done) begin
            st       <= IDLE;
            loser_r  <= 1'b0;
            winner_r <= 1'b0;
            tick_cnt <= '0;
            phase    <= '0;
          end
        end

        default: begin
          st       <= IDLE;
          freeze_r <= 1'b1;
          loser_r  <= 1'b0;
          winner_r <= 1'b0;
          tick_cnt <= '0;
          phase    <= '0;
        end
      endcase
    end
  end

  assign bus.loser        = loser_r;
  assign bus.winner       = winner_r;
  assign bus.game_freeze  = freeze_r;
  assign bus.game_restart = restart_r;
  assign bus.lives        = lives_r;
  assign bus.state        = st;

endmodule
